// File: rtl/decode_stage.sv
`timescale 1ns / 1ps
// Decode stage: one-entry RD register holding the fetched instruction, and an
// EX register holding its decoded fields. A load in EX whose destination is read
// by the instruction in RD stalls RD for one cycle and inserts a bubble into EX.
// PC_W is expected in 27..30 so that the jump target keeps at least one PC bit.
module decode_stage #(
  parameter int unsigned PC_W      = 30,
  parameter int unsigned LINK_REG  = 31,
  parameter int unsigned HAZARD_EN = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  // fetch side
  input  logic             if_valid,
  input  logic [31:0]      if_ins,
  input  logic [PC_W-1:0]  if_pc4,
  output logic             rd_ready,
  input  logic             flush,
  // control decoder handshake
  output logic [31:0]      rd_ins,
  input  logic [1:0]       imm_ctl,
  input  logic [1:0]       reg_dest_ctl,
  input  logic             uses_rs,
  input  logic             uses_rt,
  input  logic             is_load,
  // register file read addresses
  output logic [4:0]       rf_rs,
  output logic [4:0]       rf_rt,
  // EX side
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_dest,
  output logic [4:0]       ex_sa,
  output logic [31:0]      ex_imm,
  output logic [PC_W-1:0]  ex_tgt,
  output logic [PC_W-1:0]  ex_pc4,
  output logic             ex_is_load,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [4:0] LinkIdx  = 5'(LINK_REG);
  localparam bit         HazardOn = (HAZARD_EN != 0);

  // RD register
  logic            rd_valid_q;
  logic [31:0]     rd_ins_q;
  logic [PC_W-1:0] rd_pc4_q;

  // EX register
  logic            ex_valid_q;
  logic [4:0]      ex_rs_q;
  logic [4:0]      ex_rt_q;
  logic [4:0]      ex_dest_q;
  logic [4:0]      ex_sa_q;
  logic [31:0]     ex_imm_q;
  logic [PC_W-1:0] ex_tgt_q;
  logic [PC_W-1:0] ex_pc4_q;
  logic            ex_is_load_q;

  logic [CNT_W-1:0] stall_q;

  // Handshake and decode results
  logic            hazard;
  logic            advance;
  logic            bubble;
  logic            rd_load;
  logic [4:0]      dec_rs;
  logic [4:0]      dec_rt;
  logic [4:0]      dec_sa;
  logic [4:0]      dec_dest;
  logic [31:0]     dec_imm;
  logic [PC_W-1:0] dec_tgt;

  assign dec_rs = rd_ins_q[25:21];
  assign dec_rt = rd_ins_q[20:16];
  assign dec_sa = rd_ins_q[10:6];
  // Jump target keeps the upper PC region of the following instruction.
  assign dec_tgt = {rd_pc4_q[PC_W-1:26], rd_ins_q[25:0]};

  // Load-use interlock and pipeline advance conditions
  always_comb begin
    hazard = 1'b0;
    if (HazardOn && rd_valid_q && ex_valid_q && ex_is_load_q && (ex_dest_q != 5'd0)) begin
      hazard = (uses_rs && (dec_rs == ex_dest_q)) || (uses_rt && (dec_rt == ex_dest_q));
    end
    advance  = rd_valid_q && !hazard && (!ex_valid_q || ex_ready);
    rd_ready = !rd_valid_q || advance;
    rd_load  = if_valid && rd_ready && !flush;
    // A bubble is only counted when it actually replaces the EX contents.
    bubble   = hazard && ex_ready && !flush;
  end

  // Immediate extension selected by the control decoder
  always_comb begin
    dec_imm = 32'h0;
    unique case (imm_ctl)
      2'd0:    dec_imm = {16'h0, rd_ins_q[15:0]};
      2'd1:    dec_imm = {{16{rd_ins_q[15]}}, rd_ins_q[15:0]};
      2'd2:    dec_imm = {rd_ins_q[15:0], 16'h0};
      default: dec_imm = 32'h0;
    endcase
  end

  // Destination register selected by the control decoder
  always_comb begin
    dec_dest = 5'd0;
    unique case (reg_dest_ctl)
      2'd0:    dec_dest = dec_rt;
      2'd1:    dec_dest = rd_ins_q[15:11];
      2'd2:    dec_dest = LinkIdx;
      default: dec_dest = 5'd0;
    endcase
  end

  // RD register: flush wins, then a new fetch, then drain on advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_ins_q   <= 32'h0;
      rd_pc4_q   <= '0;
    end else if (flush) begin
      rd_valid_q <= 1'b0;
    end else if (rd_load) begin
      rd_valid_q <= 1'b1;
      rd_ins_q   <= if_ins;
      rd_pc4_q   <= if_pc4;
    end else if (advance) begin
      rd_valid_q <= 1'b0;
    end
  end

  // EX register: capture on advance, empty out when EX consumes without refill
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q   <= 1'b0;
      ex_rs_q      <= 5'd0;
      ex_rt_q      <= 5'd0;
      ex_dest_q    <= 5'd0;
      ex_sa_q      <= 5'd0;
      ex_imm_q     <= 32'h0;
      ex_tgt_q     <= '0;
      ex_pc4_q     <= '0;
      ex_is_load_q <= 1'b0;
    end else if (flush) begin
      ex_valid_q   <= 1'b0;
      ex_is_load_q <= 1'b0;
    end else if (advance) begin
      ex_valid_q   <= 1'b1;
      ex_rs_q      <= dec_rs;
      ex_rt_q      <= dec_rt;
      ex_dest_q    <= dec_dest;
      ex_sa_q      <= dec_sa;
      ex_imm_q     <= dec_imm;
      ex_tgt_q     <= dec_tgt;
      ex_pc4_q     <= rd_pc4_q;
      ex_is_load_q <= is_load;
    end else if (ex_ready) begin
      // Either a hazard bubble or nothing waiting in RD.
      ex_valid_q   <= 1'b0;
      ex_is_load_q <= 1'b0;
    end
  end

  // Saturating count of inserted hazard bubbles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (bubble && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign rd_ins      = rd_ins_q;
  assign rf_rs       = dec_rs;
  assign rf_rt       = dec_rt;
  assign ex_valid    = ex_valid_q;
  assign ex_rs       = ex_rs_q;
  assign ex_rt       = ex_rt_q;
  assign ex_dest     = ex_dest_q;
  assign ex_sa       = ex_sa_q;
  assign ex_imm      = ex_imm_q;
  assign ex_tgt      = ex_tgt_q;
  assign ex_pc4      = ex_pc4_q;
  assign ex_is_load  = ex_is_load_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
`timescale 1ns / 1ps
// Bench for decode_stage: two instances (interlock on / off) share the fetch,
// flush and EX-ready stimulus; each has its own control decoder and is compared
// every cycle against a transaction-level pipeline model.
module tb_decode_stage;

  localparam int unsigned PcW  = 30;
  localparam int unsigned CntW = 4;

  logic           clk      = 1'b0;
  logic           reset    = 1'b1;
  logic           if_valid = 1'b0;
  logic [31:0]    if_ins   = 32'h0;
  logic [PcW-1:0] if_pc4   = '0;
  logic           flush    = 1'b0;
  logic           ex_ready = 1'b0;

  // Control decoder override for immediate / destination checks
  logic           force_en = 1'b0;
  logic [1:0]     f_imm    = 2'd0;
  logic [1:0]     f_dest   = 2'd0;

  logic            rd_ready_w   [2];
  logic [31:0]     rd_ins_w     [2];
  logic [1:0]      imm_ctl_w    [2];
  logic [1:0]      dest_ctl_w   [2];
  logic            urs_w        [2];
  logic            urt_w        [2];
  logic            ld_w         [2];
  logic [4:0]      rf_rs_w      [2];
  logic [4:0]      rf_rt_w      [2];
  logic            ex_valid_w   [2];
  logic [4:0]      ex_rs_w      [2];
  logic [4:0]      ex_rt_w      [2];
  logic [4:0]      ex_dest_w    [2];
  logic [4:0]      ex_sa_w      [2];
  logic [31:0]     ex_imm_w     [2];
  logic [PcW-1:0]  ex_tgt_w     [2];
  logic [PcW-1:0]  ex_pc4_w     [2];
  logic            ex_is_load_w [2];
  logic [CntW-1:0] stall_w      [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Bench control decoder: {imm_ctl, reg_dest_ctl, uses_rs, uses_rt, is_load}
  function automatic logic [6:0] ctl_of(input logic [31:0] ins, input logic fe,
                                        input logic [1:0] fi, input logic [1:0] fd);
    logic [5:0] op;
    op = ins[31:26];
    if (fe) return {fi, fd, 1'b1, 1'b1, 1'b0};
    case (op)
      6'h23:   return {2'd1, 2'd0, 1'b1, 1'b0, 1'b1};  // lw
      6'h00:   return {2'd3, 2'd1, 1'b1, 1'b1, 1'b0};  // R-type ALU
      6'h0F:   return {2'd2, 2'd0, 1'b0, 1'b0, 1'b0};  // lui
      default: return {op[1:0], op[3:2], op[4], op[5], op[0] ^ op[2]};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    always_comb begin
      {imm_ctl_w[g], dest_ctl_w[g], urs_w[g], urt_w[g], ld_w[g]} =
          ctl_of(rd_ins_w[g], force_en, f_imm, f_dest);
    end

    decode_stage #(
      .PC_W     (PcW),
      .LINK_REG (31),
      .HAZARD_EN(g == 0 ? 1 : 0),
      .CNT_W    (CntW)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .if_valid    (if_valid),
      .if_ins      (if_ins),
      .if_pc4      (if_pc4),
      .rd_ready    (rd_ready_w[g]),
      .flush       (flush),
      .rd_ins      (rd_ins_w[g]),
      .imm_ctl     (imm_ctl_w[g]),
      .reg_dest_ctl(dest_ctl_w[g]),
      .uses_rs     (urs_w[g]),
      .uses_rt     (urt_w[g]),
      .is_load     (ld_w[g]),
      .rf_rs       (rf_rs_w[g]),
      .rf_rt       (rf_rt_w[g]),
      .ex_ready    (ex_ready),
      .ex_valid    (ex_valid_w[g]),
      .ex_rs       (ex_rs_w[g]),
      .ex_rt       (ex_rt_w[g]),
      .ex_dest     (ex_dest_w[g]),
      .ex_sa       (ex_sa_w[g]),
      .ex_imm      (ex_imm_w[g]),
      .ex_tgt      (ex_tgt_w[g]),
      .ex_pc4      (ex_pc4_w[g]),
      .ex_is_load  (ex_is_load_w[g]),
      .stall_count (stall_w[g])
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit             m_rd_v   [2];
  logic [31:0]    m_rd_ins [2];
  logic [PcW-1:0] m_rd_pc4 [2];
  bit             m_ex_v   [2];
  bit             m_ex_ld  [2];
  logic [4:0]     m_ex_rs  [2];
  logic [4:0]     m_ex_rt  [2];
  logic [4:0]     m_ex_dest[2];
  logic [4:0]     m_ex_sa  [2];
  logic [31:0]    m_ex_imm [2];
  logic [PcW-1:0] m_ex_tgt [2];
  logic [PcW-1:0] m_ex_pc4 [2];
  int             m_stall  [2];

  function automatic logic [31:0] exp_imm(input logic [31:0] ins, input logic [1:0] c);
    int unsigned u;
    u = 32'(ins[15:0]);
    case (c)
      2'd0:    return u;
      2'd1:    return ins[15] ? u + 32'hFFFF_0000 : u;
      2'd2:    return u * 65536;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [4:0] exp_dest(input logic [31:0] ins, input logic [1:0] c);
    case (c)
      2'd0:    return ins[20:16];
      2'd1:    return ins[15:11];
      2'd2:    return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_rd_v[k] = 0; m_rd_ins[k] = '0; m_rd_pc4[k] = '0;
      m_ex_v[k] = 0; m_ex_ld[k] = 0; m_ex_rs[k] = '0; m_ex_rt[k] = '0;
      m_ex_dest[k] = '0; m_ex_sa[k] = '0; m_ex_imm[k] = '0; m_ex_tgt[k] = '0;
      m_ex_pc4[k] = '0; m_stall[k] = 0;
    end
  endtask

  // Compare one instance against the model, then advance the model one clock.
  task automatic model_step(input int k);
    logic [6:0]     c;
    logic [4:0]     rs, rt;
    logic [PcW-1:0] mask;
    bit             hz, adv, rdy;
    c    = ctl_of(m_rd_ins[k], force_en, f_imm, f_dest);
    rs   = m_rd_ins[k][25:21];
    rt   = m_rd_ins[k][20:16];
    hz   = (k == 0) && m_rd_v[k] && m_ex_v[k] && m_ex_ld[k] && (m_ex_dest[k] != 0) &&
           ((c[2] && rs == m_ex_dest[k]) || (c[1] && rt == m_ex_dest[k]));
    adv  = m_rd_v[k] && !hz && (!m_ex_v[k] || ex_ready);
    rdy  = !m_rd_v[k] || adv;

    check_eq($sformatf("u%0d.rd_ready", k), rd_ready_w[k], rdy);
    check_eq($sformatf("u%0d.ex_valid", k), ex_valid_w[k], m_ex_v[k]);
    check_eq($sformatf("u%0d.stall", k), stall_w[k], m_stall[k]);
    if (m_rd_v[k]) begin
      check_eq($sformatf("u%0d.rd_ins", k), rd_ins_w[k], m_rd_ins[k]);
      check_eq($sformatf("u%0d.rf_rs_rt", k), {rf_rs_w[k], rf_rt_w[k]}, {rs, rt});
    end
    if (m_ex_v[k]) begin
      check_eq($sformatf("u%0d.ex_regs", k), {ex_rs_w[k], ex_rt_w[k], ex_sa_w[k]},
               {m_ex_rs[k], m_ex_rt[k], m_ex_sa[k]});
      check_eq($sformatf("u%0d.ex_dest", k), ex_dest_w[k], m_ex_dest[k]);
      check_eq($sformatf("u%0d.ex_imm", k), ex_imm_w[k], m_ex_imm[k]);
      check_eq($sformatf("u%0d.ex_tgt", k), ex_tgt_w[k], m_ex_tgt[k]);
      check_eq($sformatf("u%0d.ex_pc4", k), ex_pc4_w[k], m_ex_pc4[k]);
      check_eq($sformatf("u%0d.ex_is_load", k), ex_is_load_w[k], m_ex_ld[k]);
    end

    if (flush) begin
      m_rd_v[k] = 0;
      m_ex_v[k] = 0;
      m_ex_ld[k] = 0;
    end else begin
      if (adv) begin
        mask          = {PcW{1'b1}} << 26;
        m_ex_v[k]     = 1;
        m_ex_rs[k]    = rs;
        m_ex_rt[k]    = rt;
        m_ex_sa[k]    = m_rd_ins[k][10:6];
        m_ex_dest[k]  = exp_dest(m_rd_ins[k], c[4:3]);
        m_ex_imm[k]   = exp_imm(m_rd_ins[k], c[6:5]);
        m_ex_tgt[k]   = (m_rd_pc4[k] & mask) | PcW'(m_rd_ins[k][25:0]);
        m_ex_pc4[k]   = m_rd_pc4[k];
        m_ex_ld[k]    = c[0];
      end else if (ex_ready) begin
        m_ex_v[k]  = 0;
        m_ex_ld[k] = 0;
        if (hz && m_stall[k] < (1 << CntW) - 1) m_stall[k]++;
      end
      if (if_valid && rdy) begin
        m_rd_v[k]   = 1;
        m_rd_ins[k] = if_ins;
        m_rd_pc4[k] = if_pc4;
      end else if (adv) begin
        m_rd_v[k] = 0;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // Inputs are driven at the falling edge; outputs are compared 1 ns later.
  task automatic tick();
    #1;
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl, input logic rdy);
    if_valid = v;
    if_ins   = ins;
    if_pc4   = PcW'($urandom);
    flush    = fl;
    ex_ready = rdy;
    tick();
  endtask

  // Present one instruction until the interlocked instance takes it.
  task automatic feed(input logic [31:0] ins);
    bit acc;
    acc = 0;
    for (int t = 0; t < 8 && !acc; t++) begin
      if_valid = 1'b1;
      if_ins   = ins;
      if_pc4   = PcW'($urandom);
      flush    = 1'b0;
      ex_ready = 1'b1;
      #1;
      acc = rd_ready_w[0];
      tick();
    end
    if (!acc) check_eq("feed_timeout", 64'd0, 64'd1);
  endtask

  // Asynchronous reset in the middle of a clock phase; outputs must clear at once.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("u%0d.rst_ex", k),
               {ex_valid_w[k], ex_is_load_w[k], ex_rs_w[k], ex_rt_w[k], ex_dest_w[k], ex_sa_w[k]},
               64'd0);
      check_eq($sformatf("u%0d.rst_imm_tgt", k), {ex_imm_w[k], ex_tgt_w[k]}, 64'd0);
      check_eq($sformatf("u%0d.rst_pc4_stall", k), {ex_pc4_w[k], stall_w[k]}, 64'd0);
      check_eq($sformatf("u%0d.rst_rd_ins", k), rd_ins_w[k], 64'd0);
      check_eq($sformatf("u%0d.rst_rd_ready", k), rd_ready_w[k], 64'd1);
    end
    model_clear();
    @(negedge clk);
    reset    = 1'b0;
    if_valid = 1'b0;
    flush    = 1'b0;
  endtask

  function automatic logic [31:0] gen_ins();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 3))
      0:       x[31:26] = 6'h23;
      1:       x[31:26] = 6'h00;
      default: ;
    endcase
    x[25:21] = 5'($urandom_range(0, 3));
    x[20:16] = 5'($urandom_range(0, 3));
    x[15:11] = 5'($urandom_range(0, 3));
    return x;
  endfunction

  localparam logic [31:0] LwR8  = {6'h23, 5'd0, 5'd8, 16'h0004};
  localparam logic [31:0] AddR8 = {6'h00, 5'd8, 5'd2, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] LwR0  = {6'h23, 5'd0, 5'd0, 16'h0004};
  localparam logic [31:0] AddR0 = {6'h00, 5'd0, 5'd2, 5'd9, 5'd0, 6'h20};

  initial begin
    logic [31:0] alu;
    model_clear();
    @(negedge clk);
    do_reset();

    // Three back-to-back ALU instructions, no gaps
    for (int i = 0; i < 3; i++) begin
      alu = {6'h00, 5'(i + 1), 5'd2, 5'(10 + i), 5'd0, 6'h20};
      drive(1'b1, alu, 1'b0, 1'b1);
      if (i > 0) check_eq("stream_dest", {ex_valid_w[0], ex_dest_w[0]}, {1'b1, 5'(9 + i)});
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("stream_last", {ex_valid_w[0], ex_dest_w[0]}, {1'b1, 5'd12});

    // Load-use pair: one bubble on the interlocked instance only
    do_reset();
    drive(1'b1, LwR8, 1'b0, 1'b1);
    drive(1'b1, AddR8, 1'b0, 1'b1);
    check_eq("lu_lw_in_ex", {ex_valid_w[0], ex_is_load_w[0]}, 2'b11);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("lu_bubble", ex_valid_w[0], 1'b0);
    check_eq("lu_nohaz_issue", {ex_valid_w[1], ex_rs_w[1]}, {1'b1, 5'd8});
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("lu_add_issue", {ex_valid_w[0], ex_rs_w[0]}, {1'b1, 5'd8});
    check_eq("lu_stall", stall_w[0], 4'd1);
    check_eq("lu_nohaz_stall", stall_w[1], 4'd0);

    // Same pair targeting register 0: no interlock
    do_reset();
    drive(1'b1, LwR0, 1'b0, 1'b1);
    drive(1'b1, AddR0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("r0_no_bubble", ex_valid_w[0], 1'b1);
    check_eq("r0_stall", stall_w[0], 4'd0);

    // Immediate forms and link destination
    force_en = 1'b1; f_imm = 2'd2; f_dest = 2'd0;
    drive(1'b1, 32'h3C01_8001, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("imm_hi", {ex_imm_w[0], ex_dest_w[0]}, {32'h8001_0000, 5'd1});
    f_imm = 2'd1; f_dest = 2'd2;
    drive(1'b1, 32'h3C01_8001, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("imm_sext_link", {ex_imm_w[0], ex_dest_w[0]}, {32'hFFFF_8001, 5'd31});
    force_en = 1'b0;

    // Back-pressure with RD and EX full, then flush with a simultaneous fetch
    do_reset();
    drive(1'b1, {6'h00, 5'd1, 5'd2, 5'd3, 11'h0}, 1'b0, 1'b0);
    drive(1'b1, {6'h00, 5'd4, 5'd5, 5'd6, 11'h0}, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
      check_eq("bp_hold", {rd_ready_w[0], ex_valid_w[0], ex_rs_w[0], rd_ins_w[0][25:21]},
               {1'b0, 1'b1, 5'd1, 5'd4});
    end
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check_eq("flush_clear", {ex_valid_w[0], rd_ready_w[0], ex_valid_w[1]}, 3'b010);

    // Saturate the 4-bit stall counter, then reset mid-stream
    do_reset();
    for (int i = 0; i < 18; i++) begin
      feed(LwR8);
      feed(AddR8);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("sat_stall", stall_w[0], 4'hF);
    check_eq("sat_nohaz", stall_w[1], 4'h0);
    feed(LwR8);
    feed(AddR8);
    do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        drive(($urandom_range(0, 3) != 0), gen_ins(), ($urandom_range(0, 31) == 0),
              ($urandom_range(0, 3) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
